// File: rtl/sr595_serial_tx.sv
// Serializer feeding a 74HC595 chain: valid/ready word in, SHCP/DS shifting, STCP latch, OE gating.
// Optional PWM dimming of OE is enabled with `define SR595_DIM_EN (adds i_duty[3:0]).
module sr595_serial_tx #(
  parameter int unsigned DW        = 16,
  parameter int unsigned DIV       = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
`ifdef SR595_DIM_EN
  input  logic [3:0]    i_duty,
`endif
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_stcp,
  output logic          o_shcp,
  output logic          o_ds,
  output logic          o_oe
);

  localparam int unsigned DIV_W = $clog2(DIV + 1);
  localparam int unsigned BIT_W = $clog2(DW + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SH_LO = 2'd1,
    ST_SH_HI = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             latched_q, latched_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             stcp_q, stcp_d;
  logic             shcp_q, shcp_d;
  logic             ds_q, ds_d;
  logic             oe_q, oe_d;
  logic             div_last;
  logic             cur_bit;
  logic [DW-1:0]    shift_adv;
`ifdef SR595_DIM_EN
  logic [3:0]       pwm_q, pwm_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    div_d     = div_q;
    latched_d = latched_q;
    div_last  = (div_q == DIV_W'(DIV - 1));
    shift_adv = (MSB_FIRST != 0) ? {shift_q[DW-2:0], 1'b0} : {1'b0, shift_q[DW-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          shift_d = i_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = ST_SH_LO;
        end
      end
      ST_SH_LO: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SH_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SH_HI: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == BIT_W'(DW - 1)) begin
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_adv;
            state_d = ST_SH_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        if (div_last) begin
          div_d     = '0;
          bit_d     = '0;
          latched_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are derived from the next state so every output is a flop.
    cur_bit = (MSB_FIRST != 0) ? shift_d[DW-1] : shift_d[0];
    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
    shcp_d  = (state_d == ST_SH_HI);
    stcp_d  = (state_d == ST_LATCH);
    ds_d    = ((state_d == ST_SH_LO) || (state_d == ST_SH_HI)) && cur_bit;
`ifdef SR595_DIM_EN
    pwm_d   = pwm_q + 4'd1;
    oe_d    = latched_d ? ~(pwm_q < i_duty) : 1'b1;
`else
    oe_d    = ~latched_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      latched_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      stcp_q    <= 1'b0;
      shcp_q    <= 1'b0;
      ds_q      <= 1'b0;
      oe_q      <= 1'b1;
`ifdef SR595_DIM_EN
      pwm_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      latched_q <= latched_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      stcp_q    <= stcp_d;
      shcp_q    <= shcp_d;
      ds_q      <= ds_d;
      oe_q      <= oe_d;
`ifdef SR595_DIM_EN
      pwm_q     <= pwm_d;
`endif
    end
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_stcp  = stcp_q;
  assign o_shcp  = shcp_q;
  assign o_ds    = ds_q;
  assign o_oe    = oe_q;

endmodule
